// File: rtl/rat_intr_ctrl_pkg.sv
// Shared types and defaults for the RAT MCU interrupt controller.
package rat_intr_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SVC} intr_state_t;
  localparam int N_SRC_DEF = 8;
endpackage

// File: rtl/rat_intr_ctrl_if.sv
// Interrupt controller bus: CPU/peripheral side (master) and controller side (slave).
interface rat_intr_ctrl_if #(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
);
  logic [N_SRC-1:0] IRQ;
  logic             I_EN;
  logic             INT_ACK;
  logic             RETI;
  logic             MASK_WE;
  logic [N_SRC-1:0] MASK_DIN;
  logic             INTV;
  logic [VEC_W-1:0] VEC_ID;
  logic [N_SRC-1:0] PEND;
  logic [N_SRC-1:0] MASK;
  logic             IN_SVC;
  logic             SPUR_ACK;

  modport master (
    output IRQ, I_EN, INT_ACK, RETI, MASK_WE, MASK_DIN,
    input  INTV, VEC_ID, PEND, MASK, IN_SVC, SPUR_ACK
  );
  modport slave (
    input  IRQ, I_EN, INT_ACK, RETI, MASK_WE, MASK_DIN,
    output INTV, VEC_ID, PEND, MASK, IN_SVC, SPUR_ACK
  );
endinterface

// File: rtl/rat_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module rat_prio_enc #(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan high to low so the last hit (lowest index) sticks.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller: edge latch, mask, priority select,
// and a non-nesting IDLE/REQ/SVC handshake with the control unit.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input logic           clk,
  input logic           RESET,
  rat_intr_ctrl_if.slave bus
);
  logic [N_SRC-1:0] irq_q, pend, mask, rise, eligible, ack_clr;
  logic [VEC_W-1:0] vec_id, winner;
  logic             win_vld, intv, in_svc, spur;
  intr_state_t      state;

  assign rise     = bus.IRQ & ~irq_q;
  assign eligible = pend & mask;
  assign ack_clr  = (state == REQ && bus.INT_ACK) ? (N_SRC'(1) << vec_id) : '0;

  rat_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio (
    .req (eligible),
    .idx (winner),
    .vld (win_vld)
  );

  // A new edge on the bit being acknowledged wins over the clear.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      irq_q <= bus.IRQ;
      pend  <= (pend & ~ack_clr) | rise;
      if (bus.MASK_WE) mask <= bus.MASK_DIN;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      vec_id <= '0;
      intv   <= 1'b0;
      in_svc <= 1'b0;
      spur   <= 1'b0;
    end else begin
      if (bus.INT_ACK && state != REQ) spur <= 1'b1;
      unique case (state)
        IDLE: if (win_vld && bus.I_EN) begin
          state  <= REQ;
          vec_id <= winner;
          intv   <= 1'b1;
        end
        REQ: begin
          if (bus.INT_ACK) begin
            state  <= SVC;
            intv   <= 1'b0;
            in_svc <= 1'b1;
          end else if (!bus.I_EN || (bus.MASK_WE && !bus.MASK_DIN[vec_id])) begin
            // Withdrawn request: pending bit stays for a later retry.
            state <= IDLE;
            intv  <= 1'b0;
          end
        end
        SVC: if (bus.RETI) begin
          state  <= IDLE;
          in_svc <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.INTV     = intv;
  assign bus.VEC_ID   = vec_id;
  assign bus.PEND     = pend;
  assign bus.MASK     = mask;
  assign bus.IN_SVC   = in_svc;
  assign bus.SPUR_ACK = spur;
endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed scoreboard bench for rat_intr_ctrl: snapshot queue plus request-vector queue.
module tb_rat_intr_ctrl;
  logic clk = 1'b0;
  logic RESET;

  rat_intr_ctrl_if #(.N_SRC(8), .VEC_W(3)) bus ();
  rat_intr_ctrl #(.N_SRC(8), .VEC_W(3)) dut (.clk(clk), .RESET(RESET), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pend;
    logic [7:0] mask;
    logic       intv;
    logic [2:0] vec;
    logic       svc;
    logic       spur;
  } snap_t;

  snap_t snap_q[$];
  int    req_q[$];
  int    checks = 0;
  int    failures = 0;
  logic [7:0] exp_mask = 8'h00;
  logic       exp_spur = 1'b0;
  logic       intv_prev = 1'b0;

  // Snapshot monitor: compares one queued expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (snap_q.size() > 0) begin
      snap_t e;
      e = snap_q.pop_front();
      checks++;
      if (bus.PEND !== e.pend || bus.MASK !== e.mask || bus.INTV !== e.intv ||
          bus.VEC_ID !== e.vec || bus.IN_SVC !== e.svc || bus.SPUR_ACK !== e.spur) begin
        failures++;
        $display("FAIL %s: got pend=%h mask=%h intv=%b vec=%0d svc=%b spur=%b, want pend=%h mask=%h intv=%b vec=%0d svc=%b spur=%b",
                 e.name, bus.PEND, bus.MASK, bus.INTV, bus.VEC_ID, bus.IN_SVC, bus.SPUR_ACK,
                 e.pend, e.mask, e.intv, e.vec, e.svc, e.spur);
      end
    end
  end

  // Request monitor: every INTV rise must match the next expected vector.
  always @(negedge clk) begin
    if (bus.INTV === 1'b1 && !intv_prev) begin
      checks++;
      if (req_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_request: got vec=%0d, want no request", bus.VEC_ID);
      end else begin
        int v;
        v = req_q.pop_front();
        if (int'(bus.VEC_ID) != v) begin
          failures++;
          $display("FAIL request_vec: got vec=%0d, want %0d", bus.VEC_ID, v);
        end
      end
    end
    intv_prev = (bus.INTV === 1'b1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input string name, input logic [7:0] pend, input logic intv,
                      input logic [2:0] vec, input logic svc);
    snap_t s;
    s.name = name; s.pend = pend; s.mask = exp_mask; s.intv = intv;
    s.vec = vec; s.svc = svc; s.spur = exp_spur;
    snap_q.push_back(s);
  endtask

  task automatic ack_reti();
    bus.INT_ACK = 1'b1; step(); bus.INT_ACK = 1'b0;
    bus.RETI = 1'b1;    step(); bus.RETI = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.MASK_WE = 1'b1; bus.MASK_DIN = m; step();
    bus.MASK_WE = 1'b0; exp_mask = m;
  endtask

  initial begin
    RESET = 1'b1;
    bus.IRQ = '0; bus.I_EN = 1'b0; bus.INT_ACK = 1'b0; bus.RETI = 1'b0;
    bus.MASK_WE = 1'b0; bus.MASK_DIN = '0;
    step(3);
    RESET = 1'b0;
    snap("reset", 8'h00, 0, 0, 0);
    step();

    // Single source: PEND at edge k, INTV one edge later, ACK clears.
    bus.I_EN = 1'b1;
    write_mask(8'hFF);
    req_q.push_back(5);
    bus.IRQ = 8'h20; step(); bus.IRQ = '0;
    snap("irq5_pend", 8'h20, 0, 0, 0);
    step();
    snap("irq5_req", 8'h20, 1, 5, 0);
    bus.INT_ACK = 1'b1; step(); bus.INT_ACK = 1'b0;
    snap("irq5_ack", 8'h00, 0, 5, 1);
    bus.RETI = 1'b1; step(); bus.RETI = 1'b0;
    snap("irq5_reti", 8'h00, 0, 5, 0);

    // Simultaneous 6 and 2: 2 first, 6 right after return.
    req_q.push_back(2); req_q.push_back(6);
    bus.IRQ = 8'h44; step(); bus.IRQ = '0;
    step();
    snap("prio_req2", 8'h44, 1, 2, 0);
    bus.INT_ACK = 1'b1; step(); bus.INT_ACK = 1'b0;
    snap("prio_ack2", 8'h40, 0, 2, 1);
    bus.RETI = 1'b1; step(); bus.RETI = 1'b0;
    snap("prio_reti", 8'h40, 0, 2, 0);
    step();
    snap("prio_req6", 8'h40, 1, 6, 0);
    ack_reti();
    snap("prio_done", 8'h00, 0, 6, 0);

    // No preemption in REQ; I_EN drop withdraws but keeps PEND.
    req_q.push_back(4); req_q.push_back(1); req_q.push_back(4);
    bus.IRQ = 8'h10; step(); bus.IRQ = '0;
    step();
    snap("frz_req4", 8'h10, 1, 4, 0);
    bus.IRQ = 8'h02; step(); bus.IRQ = '0;
    snap("frz_hold4", 8'h12, 1, 4, 0);
    bus.I_EN = 1'b0; step();
    snap("frz_withdraw", 8'h12, 0, 4, 0);
    bus.I_EN = 1'b1; step();
    snap("frz_req1", 8'h12, 1, 1, 0);
    ack_reti();
    step();
    ack_reti();
    snap("frz_done", 8'h00, 0, 4, 0);

    // Masked pending raises a request once unmasked; mask write withdraws.
    req_q.push_back(3); req_q.push_back(3);
    write_mask(8'h00);
    bus.IRQ = 8'h08; step(); bus.IRQ = '0;
    step();
    snap("mask_block", 8'h08, 0, 4, 0);
    write_mask(8'h08);
    snap("mask_open", 8'h08, 0, 4, 0);
    step();
    snap("mask_req3", 8'h08, 1, 3, 0);
    write_mask(8'h00);
    snap("mask_withdraw", 8'h08, 0, 3, 0);
    write_mask(8'h08);
    step();
    snap("mask_rereq3", 8'h08, 1, 3, 0);

    // New edge on the bit being acknowledged keeps it pending.
    req_q.push_back(3);
    bus.INT_ACK = 1'b1; bus.IRQ = 8'h08; step();
    bus.INT_ACK = 1'b0; bus.IRQ = '0;
    snap("ack_setclr", 8'h08, 0, 3, 1);
    bus.RETI = 1'b1; step(); bus.RETI = 1'b0;
    step();
    snap("ack_rereq", 8'h08, 1, 3, 0);
    ack_reti();
    snap("ack_done", 8'h00, 0, 3, 0);

    // Spurious ACK is sticky; RETI in IDLE does nothing.
    bus.INT_ACK = 1'b1; step(); bus.INT_ACK = 1'b0;
    exp_spur = 1'b1;
    snap("spur_set", 8'h00, 0, 3, 0);
    step();
    snap("spur_hold", 8'h00, 0, 3, 0);
    bus.RETI = 1'b1; step(); bus.RETI = 1'b0;
    snap("reti_idle", 8'h00, 0, 3, 0);

    // Held level requests once.
    write_mask(8'hFF);
    req_q.push_back(0);
    bus.IRQ = 8'h01; step();
    snap("lvl_pend", 8'h01, 0, 3, 0);
    step();
    snap("lvl_req0", 8'h01, 1, 0, 0);
    ack_reti();
    step(5);
    snap("lvl_once", 8'h00, 0, 0, 0);
    bus.IRQ = '0; step();

    // Asynchronous reset while requesting.
    req_q.push_back(0);
    bus.IRQ = 8'h05; step(); bus.IRQ = '0;
    step();
    snap("rst_pre", 8'h05, 1, 0, 0);
    step();
    #1;
    RESET = 1'b1;
    exp_mask = 8'h00; exp_spur = 1'b0;
    snap("rst_async", 8'h00, 0, 0, 0);
    step();
    RESET = 1'b0;
    step();
    snap("rst_after", 8'h00, 0, 0, 0);
    step(3);

    checks++;
    if (req_q.size() != 0 || snap_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d requests and %0d snapshots outstanding, want 0 and 0",
               req_q.size(), snap_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
